uart_txq: RTL

UART_TXQ -- requirements
Module: uart_txq

---
 rtl/uart_txq.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_txq.sv
// rtl/uart_txq.sv - UART transmitter with push FIFO, parity/stop framing, break and flow control
module uart_txq #(
    parameter int DATA_W     = 9,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16,
    parameter int TRIG_LVL   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable_i,
    input  logic [DIV_W-1:0]            div_i,
    input  logic [3:0]                  len_i,
    input  logic [1:0]                  pdsel_i,
    input  logic                        stsel_i,
    input  logic                        txinv_i,
    input  logic                        fce_i,
    input  logic                        cts_i,
    input  logic                        txbrk_i,
    input  logic                        wr_valid_i,
    input  logic [DATA_W-1:0]           wr_data_i,
    output logic                        wr_ready_o,
    output logic                        txd_o,
    output logic [$clog2(FIFO_DEPTH):0] level_o,
    output logic                        empty_o,
    output logic                        busy_o,
    output logic                        tx_trig_o,
    output logic                        ovf_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wptr, r_rptr;
    logic [AW:0]       r_level;

    state_t            r_state, w_state_nxt;
    logic [DIV_W-1:0]  r_cnt, r_div;
    logic [DATA_W-1:0] r_shift;
    logic [3:0]        r_len, r_bitidx;
    logic [1:0]        r_pdsel;
    logic              r_stsel, r_stop2, r_par, r_txd;

    logic              w_full, w_empty, w_push, w_pop, w_brk_start, w_shift_en;
    logic              w_stop_second, w_launch, w_boundary, w_can_pop, w_line, w_xor, w_par;
    logic [3:0]        w_len;
    logic [DATA_W-1:0] w_head;

    assign w_full     = (r_level == (AW+1)'(FIFO_DEPTH));
    assign w_empty    = (r_level == '0);
    assign w_push     = wr_valid_i && !w_full;
    assign w_head     = r_mem[r_rptr];
    assign w_boundary = (r_cnt == r_div);
    assign w_can_pop  = !w_empty && (!fce_i || cts_i);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= wr_data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Frame length clamp and parity are taken from the FIFO head at the moment of the pop
    always_comb begin
        w_len = len_i;
        if (len_i < 4'd5)
            w_len = 4'd5;
        else if (len_i > 4'(DATA_W))
            w_len = 4'(DATA_W);
        w_xor = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < int'(w_len)) w_xor = w_xor ^ w_head[i];
        end
        case (pdsel_i)
            2'b01:   w_par = w_xor;
            2'b10:   w_par = ~w_xor;
            default: w_par = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pop         = 1'b0;
        w_brk_start   = 1'b0;
        w_shift_en    = 1'b0;
        w_stop_second = 1'b0;
        w_launch      = 1'b0;
        w_line        = 1'b1;
        case (r_state)
            S_IDLE:   w_launch = 1'b1;
            S_START:  if (w_boundary) w_state_nxt = S_DATA;
            S_DATA: begin
                if (w_boundary) begin
                    if (r_bitidx == r_len - 4'd1)
                        w_state_nxt = (r_pdsel != 2'b00) ? S_PARITY : S_STOP;
                    else
                        w_shift_en = 1'b1;
                end
            end
            S_PARITY: if (w_boundary) w_state_nxt = S_STOP;
            S_STOP: begin
                if (w_boundary) begin
                    if (r_stsel && !r_stop2) w_stop_second = 1'b1;
                    else                     w_launch      = 1'b1;
                end
            end
            S_BREAK:  if (w_boundary && !txbrk_i) w_state_nxt = S_STOP;
            default:  w_state_nxt = S_IDLE;
        endcase
        // The end of a stop bit makes the same decision as IDLE so frames run back-to-back
        if (w_launch) begin
            if (txbrk_i) begin
                w_state_nxt = S_BREAK;
                w_brk_start = 1'b1;
            end else if (w_can_pop) begin
                w_state_nxt = S_START;
                w_pop       = 1'b1;
            end else begin
                w_state_nxt = S_IDLE;
            end
        end
        if (!enable_i) begin
            w_state_nxt   = S_IDLE;
            w_pop         = 1'b0;
            w_brk_start   = 1'b0;
            w_shift_en    = 1'b0;
            w_stop_second = 1'b0;
        end
        case (w_state_nxt)
            S_START, S_BREAK: w_line = 1'b0;
            S_DATA:           w_line = w_shift_en ? r_shift[1] : r_shift[0];
            S_PARITY:         w_line = r_par;
            default:          w_line = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_div    <= '0;
            r_shift  <= '0;
            r_len    <= '0;
            r_bitidx <= '0;
            r_pdsel  <= '0;
            r_stsel  <= 1'b0;
            r_stop2  <= 1'b0;
            r_par    <= 1'b0;
            r_txd    <= txinv_i;
        end else begin
            r_txd <= w_line ^ txinv_i;
            if (r_state == S_IDLE || w_boundary || w_state_nxt != r_state)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + DIV_W'(1);
            if (w_pop) begin
                r_shift  <= w_head;
                r_len    <= w_len;
                r_pdsel  <= pdsel_i;
                r_stsel  <= stsel_i;
                r_div    <= div_i;
                r_par    <= w_par;
                r_bitidx <= '0;
                r_stop2  <= 1'b0;
            end else if (w_brk_start) begin
                r_stsel  <= stsel_i;
                r_div    <= div_i;
                r_stop2  <= 1'b0;
            end else begin
                if (w_shift_en) begin
                    r_shift  <= r_shift >> 1;
                    r_bitidx <= r_bitidx + 4'd1;
                end
                if (w_stop_second) r_stop2 <= 1'b1;
            end
        end
    end

    assign wr_ready_o = !w_full;
    assign ovf_o      = wr_valid_i && w_full;
    assign level_o    = r_level;
    assign empty_o    = w_empty;
    assign busy_o     = (r_state != S_IDLE);
    assign tx_trig_o  = (r_level <= (AW+1)'(TRIG_LVL));
    assign txd_o      = r_txd;
endmodule
